lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit between the CPU datapath and the data memory (`MEM`). It turns one CPU load/store request into one or more memory accesses of the kind `MEM` supports: `SB`, `SH` at halfword offset, and `SW` at word offset. It extracts and sign- or zero-extends load data from the raw word `MEM` returns. Optionally, it splits misaligned accesses into several memory cycles, using a small FSM with a valid/ready request handshake and a one-cycle response pulse.

## Interface
Parameters: none (address and data fixed at 32 bits).

Ports:
- `clk` in 1 — single clock; all state updates on posedge.
- `rst` in 1 — asynchronous, active-high reset.
- `req_valid` in 1 — CPU request present.
- `req_ready` out 1 — unit can accept a request; equals (state == IDLE).
- `req_we` in 1 — 1 = store, 0 = load.
- `req_type` in 3 — RISC-V funct3:
  - loads: LB 000, LH 001, LW 010, LBU 100, LHU 101;
  - stores: SB 000, SH 001, SW 010.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned.
- `resp_valid` out 1 — one-cycle completion pulse.
- `resp_rdata` out 32 — extended load result; 0 for stores and faults.
- `resp_fault` out 1 — valid with `resp_valid`; the access was not performed.
- `mem_we` out 1 — `MEM` write enable.
- `mem_type` out 3 — `MEM` write_type (SB 000 / SH 001 / SW 010).
- `mem_addr` out 32 — `MEM` byte address.
- `mem_wdata` out 32 — `MEM` data_in.
- `mem_rdata` in 32 — `MEM` data_out; a combinational read of word `mem_addr>>2`.

## Operation
- **Byte order** matches `MEM`. Byte offset k of a word sits at bits [31-8k -: 8]. Multi-byte values are big-endian: the lowest address holds the most significant byte.
- **Misaligned** means: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- **Illegal type** means: a load with funct3 011/110/111, or a store with funct3 ≥ 011. An illegal type always faults.

FSM:
- **IDLE:** `req_ready`=1. On `req_valid`, the request fields are latched.
  - Aligned and legal → ISSUE with op count n=1.
  - Misaligned → handled per Configuration.
  - Illegal → RESP with fault.
- **ISSUE:** drives one memory op per cycle. An op counter k runs from 0 to n-1; the last op goes to RESP, otherwise stay in ISSUE with k+1.
  - Aligned store: `mem_we`=1, `mem_type`=req_type, `mem_addr`=req_addr, `mem_wdata`=req_wdata.
  - Load: `mem_we`=0, `mem_type`=010, `mem_addr`=word address for op k. `mem_rdata` is captured into word buffer k at the posedge.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE.
  - For loads, `resp_rdata` is built from the buffered word(s), taking bytes at offset addr[1:0] onward.
  - LB/LH are sign-extended; LBU/LHU/LW are zero-/pass-through.

Other rules:
- `mem_we` is asserted only in ISSUE for stores.
- Outside ISSUE, all `mem_*` outputs are 0.
- `req_*` inputs are ignored while not in IDLE; a held `req_valid` is accepted on the first IDLE cycle.
- Address arithmetic is modulo 2^32: a word at 0xFFFFFFFC+4 wraps to 0.

## Timing
- Request accepted at edge E0. Aligned access: ISSUE in cycle 1, `resp_valid` in cycle 2.
- Misaligned load within one word (H at offset 1): n=1.
- Misaligned load crossing a word boundary: n=2 (words A=addr&~3, then A+4), so `resp_valid` in cycle 3.
- Misaligned store: n=2 (H) or n=4 (W) byte stores at addr+i, with `mem_wdata`[7:0] = the i-th most significant byte. `resp_valid` is in cycle n+1.
- Fault: `resp_valid` + `resp_fault` in cycle 1; no memory cycle occurs.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0, all `mem_*`=0, buffers and counter 0.
- Reset mid-operation: a pending split is abandoned. Bytes already written stay written (no rollback), and no response is produced.

## Configuration
- Macro: `LSU_MISALIGN_SPLIT_EN`.
- **Defined:** misaligned accesses are split as described in Timing and complete with `resp_fault`=0.
- **Undefined:** a misaligned access goes IDLE→RESP with `resp_fault`=1 and `resp_rdata`=0, and `mem_we` is never asserted. The split counter and second word buffer are not built.

## Test plan
- **Aligned LW:** word2=0xDEADBEEF; LW 0x8 → one read at 0x8, `resp_rdata`=0xDEADBEEF, `resp_valid` exactly in cycle 2.
- **LB/LBU:** word2=0x80FF0011. LB 0x9 → 0xFFFFFFFF; LBU 0x9 → 0x000000FF; LH 0x8 → 0xFFFF80FF.
- **Aligned SH:** SH 0x6, data 0x00001234 → single ISSUE cycle with `mem_we`=1, `mem_type`=001, `mem_addr`=0x6; afterwards word1[15:0]=0x1234.
- **Split LW (macro on):** word1=0x00112233, word2=0x44556677; LW 0x5 → reads 0x4 then 0x8, `resp_rdata`=0x11223344 in cycle 3.
- **Split SW (macro on/off):**
  - On: SW 0x3, data 0xAABBCCDD → four SB cycles at 0x3/0x4/0x5/0x6 with data AA/BB/CC/DD, `resp_fault`=0 in cycle 5.
  - Off: same request → `resp_fault`=1 in cycle 1, `mem_we` never 1.
- **Reset mid-split:** `rst` pulsed during the 2nd byte of the split SW above → only byte 0x3=AA written, `req_ready`=1 immediately, no `resp_valid`. An illegal load type 011 afterwards → `resp_fault`=1.

Source files
------------

// File: rtl/lsu_align.sv
// lsu_align -- load/store alignment unit between the CPU datapath and MEM.
//
// Converts one CPU load/store request into the memory accesses MEM supports
// (SB, SH at halfword offset, SW at word offset) and extracts/extends load
// data from the raw big-endian word MEM returns (byte offset k lives at
// bits [31-8k -: 8]).
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : misaligned accesses are split into several memory cycles
//               (loads: up to two word reads, stores: per-byte SB writes).
//   undefined : misaligned accesses fault without touching memory; the op
//               counter and second word buffer are not built.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is 1 exactly while the FSM is IDLE, and
// req_* are ignored at all other times. Completion is a one-cycle
// resp_valid pulse carrying resp_rdata/resp_fault.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_type         store flag, RISC-V funct3 access type
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_fault   extended load result, access-not-performed flag
//   mem_we, mem_type         MEM write enable, write_type (SB/SH/SW)
//   mem_addr, mem_wdata      MEM byte address, data_in
//   mem_rdata                MEM data_out (combinational read of mem_addr>>2)

module lsu_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_we,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  logic        lat_we;
  logic [2:0]  lat_type;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_fault;
  logic [31:0] buf0;
  logic [31:0] buf_hi;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0] buf1;
  logic [1:0]  op_k;
  logic [1:0]  op_last;
  logic [1:0]  req_last;
  logic [31:0] st_sh;
`endif

  // Request decode
  logic req_illegal;
  logic req_misalign;

  always_comb begin
    if (req_we)
      req_illegal = (req_type >= 3'b011);
    else
      req_illegal = (req_type == 3'b011) || (req_type == 3'b110) ||
                    (req_type == 3'b111);
    req_misalign = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_type[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Index of the last memory op: split stores go byte by byte, loads need a
  // second word only when the access runs past the end of the first word.
  always_comb begin
    req_last = 2'd0;
    if (req_misalign) begin
      if (req_we)
        req_last = (req_type[1:0] == 2'b10) ? 2'd3 : 2'd1;
      else if ((req_type[1:0] == 2'b10) || (req_addr[1:0] == 2'b11))
        req_last = 2'd1;
    end
  end
`endif

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_type  <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_fault <= 1'b0;
      buf0      <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      buf1      <= 32'd0;
      op_k      <= 2'd0;
      op_last   <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_type  <= req_type;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
            op_k      <= 2'd0;
            op_last   <= req_last;
`endif
            if (req_illegal) begin
              lat_fault <= 1'b1;
              state     <= RESP;
            end else if (req_misalign) begin
`ifdef LSU_MISALIGN_SPLIT_EN
              lat_fault <= 1'b0;
              state     <= ISSUE;
`else
              lat_fault <= 1'b1;
              state     <= RESP;
`endif
            end else begin
              lat_fault <= 1'b0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (!lat_we) begin
            if (op_k == 2'd0)
              buf0 <= mem_rdata;
            else
              buf1 <= mem_rdata;
          end
          if (op_k == op_last)
            state <= RESP;
          else
            op_k <= op_k + 2'd1;
`else
          if (!lat_we)
            buf0 <= mem_rdata;
          state <= RESP;
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory port: driven only while in ISSUE
`ifdef LSU_MISALIGN_SPLIT_EN
  // Halfword stores are moved to the top of the word so that byte k of the
  // value is always the top byte after shifting by k bytes.
  always_comb begin
    st_sh = lat_type[1] ? lat_wdata : {lat_wdata[15:0], 16'd0};
    st_sh = st_sh << {op_k, 3'b000};
  end
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_type  = 3'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state == ISSUE) begin
      if (lat_we) begin
        mem_we    = 1'b1;
        mem_type  = lat_type;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (op_last != 2'd0) begin
          mem_type  = 3'b000;
          mem_addr  = lat_addr + {30'd0, op_k};
          mem_wdata = {24'd0, st_sh[31:24]};
        end
`endif
      end else begin
        mem_type = 3'b010;
`ifdef LSU_MISALIGN_SPLIT_EN
        mem_addr = {lat_addr[31:2], 2'b00} + {28'd0, op_k, 2'b00};
`else
        mem_addr = {lat_addr[31:2], 2'b00};
`endif
      end
    end
  end

  // Response
`ifdef LSU_MISALIGN_SPLIT_EN
  assign buf_hi = buf1;
`else
  assign buf_hi = 32'd0;
`endif

  logic [31:0] rd_win;

  // rd_win holds the four bytes starting at the request offset, MSB first.
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    rd_win = buf0;
      2'd1:    rd_win = {buf0[23:0], buf_hi[31:24]};
      2'd2:    rd_win = {buf0[15:0], buf_hi[31:16]};
      default: rd_win = {buf0[7:0],  buf_hi[31:8]};
    endcase
  end

  assign req_ready = (state == IDLE);

  always_comb begin
    resp_valid = (state == RESP);
    resp_fault = resp_valid && lat_fault;
    resp_rdata = 32'd0;
    if (resp_valid && !lat_fault && !lat_we) begin
      case (lat_type)
        3'b000:  resp_rdata = {{24{rd_win[31]}}, rd_win[31:24]};
        3'b001:  resp_rdata = {{16{rd_win[31]}}, rd_win[31:16]};
        3'b010:  resp_rdata = rd_win;
        3'b100:  resp_rdata = {24'd0, rd_win[31:24]};
        3'b101:  resp_rdata = {16'd0, rd_win[31:16]};
        default: resp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align -- self-checking bench for lsu_align.
// Works with LSU_MISALIGN_SPLIT_EN defined or undefined; expectations for
// misaligned accesses follow the selected build.

module tb_lsu_align;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_align dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_we     (mem_we),
    .mem_type   (mem_type),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the DUT: 16 words, address bits above [5:2] ignored
  logic [31:0] mem_w [16];
  assign mem_rdata = mem_w[mem_addr[5:2]];

  always @(posedge clk) begin : mem_model
    logic [31:0] w;
    int o;
    if (mem_we) begin
      w = mem_w[mem_addr[5:2]];
      o = int'(mem_addr[1:0]);
      case (mem_type)
        3'b000:  w[31-8*o -: 8]  = mem_wdata[7:0];
        3'b001:  w[31-8*o -: 16] = mem_wdata[15:0];
        default: w = mem_wdata;
      endcase
      mem_w[mem_addr[5:2]] = w;
    end
  end

  // Memory-op monitor
  typedef struct packed {
    logic        we;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
  } op_t;
  op_t op_q[$];
  bit  we_seen;

  always @(negedge clk) begin
    if (mem_we || mem_type != 3'd0)
      op_q.push_back('{mem_we, mem_type, mem_addr, mem_wdata});
    if (mem_we) we_seen = 1'b1;
  end

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Driver: one request, returns response fields and cycle of resp_valid
  // (1 = cycle after the accepting edge; 0 = no response within budget).
  task automatic do_req(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic flt, output int cyc);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_type  = ty;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_type  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    rd  = 32'd0;
    flt = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd  = resp_rdata;
        flt = resp_fault;
        cyc = c;
        break;
      end
    end
  endtask

  // Reference model: byte-addressed memory, spec rules in plain arithmetic
  logic [7:0] ref_b [64];

  function automatic void ref_req(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd,
                                  output logic flt, output int cyc);
    bit illegal, mis;
    int size;
    logic [31:0] v;
    illegal = we ? (ty > 3'd2) : (ty == 3'd3 || ty > 3'd5);
    rd  = 32'd0;
    flt = 1'b0;
    cyc = 1;
    if (illegal) begin
      flt = 1'b1;
      return;
    end
    size = 1 << ty[1:0];
    mis  = (addr % size) != 0;
    if (mis && !SPLIT) begin
      flt = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < size; i++)
        ref_b[(addr + i) & 63] = 8'(wd >> (8 * (size - 1 - i)));
      cyc = mis ? size + 1 : 2;
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++)
        v = (v << 8) | {24'd0, ref_b[(addr + i) & 63]};
      if (!ty[2] && size == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!ty[2] && size == 2 && v[15]) v = v | 32'hFFFF0000;
      rd  = v;
      cyc = ((addr % 4) + size > 4) ? 3 : 2;
    end
  endfunction

  // Directed vector table
  typedef struct {
    logic        we;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        flt;
    int          cyc;
  } vec_t;
  vec_t tbl[$];

  logic [31:0] g_rd;
  logic        g_flt;
  int          g_cyc;
  logic [31:0] e_rd;
  logic        e_flt;
  int          e_cyc;
  bit          resp_seen;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_type = 3'd0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    we_seen = 1'b0;
    for (int i = 0; i < 16; i++) mem_w[i] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset resp_fault", {31'd0, resp_fault}, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset mem_bus", {28'd0, mem_we, mem_type} | mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;

    // Memory image for the table
    mem_w[0]  = 32'h01020304;
    mem_w[1]  = 32'h00112233;
    mem_w[2]  = 32'h44556677;
    mem_w[3]  = 32'hDEADBEEF;
    mem_w[4]  = 32'h80FF0011;
    mem_w[15] = 32'hCAFEF00D;

    tbl.push_back('{1'b0, 3'b010, 32'h0000000C, 32'd0, 32'hDEADBEEF, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b000, 32'h00000011, 32'd0, 32'hFFFFFFFF, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b100, 32'h00000011, 32'd0, 32'h000000FF, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b001, 32'h00000010, 32'd0, 32'hFFFF80FF, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b101, 32'h00000010, 32'd0, 32'h000080FF, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b001, 32'h00000012, 32'd0, 32'h00000011, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b000, 32'h00000013, 32'd0, 32'h00000011, 1'b0, 2});
    tbl.push_back('{1'b0, 3'b010, 32'h00000005, 32'd0, SPLIT ? 32'h11223344 : 32'd0, !SPLIT, SPLIT ? 3 : 1});
    tbl.push_back('{1'b0, 3'b001, 32'h00000011, 32'd0, SPLIT ? 32'hFFFFFF00 : 32'd0, !SPLIT, SPLIT ? 2 : 1});
    tbl.push_back('{1'b0, 3'b101, 32'h00000007, 32'd0, SPLIT ? 32'h00003344 : 32'd0, !SPLIT, SPLIT ? 3 : 1});
    tbl.push_back('{1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, SPLIT ? 32'hF00D0102 : 32'd0, !SPLIT, SPLIT ? 3 : 1});
    tbl.push_back('{1'b0, 3'b011, 32'h00000008, 32'd0, 32'd0, 1'b1, 1});
    tbl.push_back('{1'b0, 3'b110, 32'h00000008, 32'd0, 32'd0, 1'b1, 1});
    tbl.push_back('{1'b1, 3'b011, 32'h00000008, 32'h12345678, 32'd0, 1'b1, 1});

    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].ty, tbl[i].addr, tbl[i].wd, g_rd, g_flt, g_cyc);
      check($sformatf("tbl%0d rdata", i), g_rd, tbl[i].rd);
      check($sformatf("tbl%0d fault", i), {31'd0, g_flt}, {31'd0, tbl[i].flt});
      check($sformatf("tbl%0d cycle", i), g_cyc, tbl[i].cyc);
    end
    check("illegal store no write", mem_w[2], 32'h44556677);

    // Aligned LW: exactly one word read at 0xC
    op_q.delete();
    do_req(1'b0, 3'b010, 32'h0000000C, 32'd0, g_rd, g_flt, g_cyc);
    check("lw ops", op_q.size(), 1);
    if (op_q.size() == 1) begin
      check("lw op addr", op_q[0].addr, 32'h0000000C);
      check("lw op type", {28'd0, op_q[0].we, op_q[0].ty}, 32'h2);
    end

    // Split LW 0x5: reads 0x4 then 0x8
    op_q.delete();
    do_req(1'b0, 3'b010, 32'h00000005, 32'd0, g_rd, g_flt, g_cyc);
    check("split lw ops", op_q.size(), SPLIT ? 2 : 0);
    if (SPLIT && op_q.size() == 2) begin
      check("split lw addr0", op_q[0].addr, 32'h4);
      check("split lw addr1", op_q[1].addr, 32'h8);
    end

    // Aligned SH 0x6
    op_q.delete();
    do_req(1'b1, 3'b001, 32'h00000006, 32'h00001234, g_rd, g_flt, g_cyc);
    check("sh fault", {31'd0, g_flt}, 32'd0);
    check("sh cycle", g_cyc, 2);
    check("sh ops", op_q.size(), 1);
    if (op_q.size() == 1)
      check("sh op", {op_q[0].we, op_q[0].ty, op_q[0].addr[27:0]}, {1'b1, 3'b001, 28'h6});
    check("sh mem word1", mem_w[1], 32'h00111234);

    // Misaligned SW 0x3
    mem_w[0] = 32'h10203040;
    mem_w[1] = 32'h50607080;
    op_q.delete();
    we_seen = 1'b0;
    do_req(1'b1, 3'b010, 32'h00000003, 32'hAABBCCDD, g_rd, g_flt, g_cyc);
    check("split sw fault", {31'd0, g_flt}, {31'd0, !SPLIT});
    check("split sw cycle", g_cyc, SPLIT ? 5 : 1);
    check("split sw ops", op_q.size(), SPLIT ? 4 : 0);
    check("split sw we_seen", {31'd0, we_seen}, {31'd0, SPLIT});
    if (SPLIT && op_q.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("split sw op%0d", i),
              {op_q[i].we, op_q[i].ty, op_q[i].addr[19:0], op_q[i].wd[7:0]},
              {1'b1, 3'b000, 20'(3 + i), 8'(32'hAABBCCDD >> (24 - 8 * i))});
    end
    check("split sw word0", mem_w[0], SPLIT ? 32'h102030AA : 32'h10203040);
    check("split sw word1", mem_w[1], SPLIT ? 32'hBBCCDD80 : 32'h50607080);

    // Reset during the second byte of the split SW
    mem_w[0] = 32'h10203040;
    mem_w[1] = 32'h50607080;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_type  = 3'b010;
    req_addr  = 32'h3;
    req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) resp_seen = 1'b1;
    end
    check("rst no response", {31'd0, resp_seen}, 32'd0);
    check("rst word0", mem_w[0], SPLIT ? 32'h102030AA : 32'h10203040);
    check("rst word1", mem_w[1], 32'h50607080);
    do_req(1'b0, 3'b011, 32'h00000000, 32'd0, g_rd, g_flt, g_cyc);
    check("post-rst illegal fault", {31'd0, g_flt}, 32'd1);
    check("post-rst illegal cycle", g_cyc, 1);

    // Randomized requests against the reference model
    for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
    for (int i = 0; i < 16; i++)
      mem_w[i] = {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]};
    for (int n = 0; n < 300; n++) begin
      logic        r_we;
      logic [2:0]  r_ty;
      logic [31:0] r_addr;
      logic [31:0] r_wd;
      r_we   = 1'($urandom);
      r_ty   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      if (!r_we && $urandom_range(0, 2) == 0) r_ty[2] = 1'b1;
      r_addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) r_addr = 32'hFFFFFFC0 | r_addr;
      if ($urandom_range(0, 1) == 0) r_addr = r_addr & ~32'((1 << r_ty[1:0]) - 1);
      r_wd   = $urandom;
      ref_req(r_we, r_ty, r_addr, r_wd, e_rd, e_flt, e_cyc);
      do_req(r_we, r_ty, r_addr, r_wd, g_rd, g_flt, g_cyc);
      check($sformatf("rnd%0d rdata we=%0d ty=%0d a=%08h", n, r_we, r_ty, r_addr), g_rd, e_rd);
      check($sformatf("rnd%0d fault", n), {31'd0, g_flt}, {31'd0, e_flt});
      check($sformatf("rnd%0d cycle", n), g_cyc, e_cyc);
    end
    for (int i = 0; i < 16; i++)
      check($sformatf("final word%0d", i), mem_w[i],
            {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
